// File: rtl/instruction_memory_loadable.sv
// Loadable instruction memory: a program is streamed in through the load port,
// then fetches are served with a request register followed by a registered read.
module instruction_memory_loadable #(
  parameter int                    DATA_WIDTH       = 32,
  parameter int                    ADDR_WIDTH       = 32,
  parameter int                    NUM_INSTRUCTIONS = 64,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD         = 32'hE1A00000,
  localparam int                   CW               = $clog2(NUM_INSTRUCTIONS + 1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_Load_Start,
  input  logic                  i_Load_Valid,
  input  logic [DATA_WIDTH-1:0] i_Load_Data,
  input  logic                  i_Load_Done,
  output logic                  o_Load_Ready,
  output logic                  o_Load_Overflow,
  output logic [CW-1:0]         o_Loaded_Count,
  output logic                  o_Run,
  input  logic                  i_Fetch_Req,
  input  logic [ADDR_WIDTH-1:0] i_Instruction_Address,
  output logic [DATA_WIDTH-1:0] o_Instruction,
  output logic                  o_Instruction_Valid,
  output logic                  o_Fault
);

  localparam int IW   = $clog2(NUM_INSTRUCTIONS);
  localparam int CMPW = ADDR_WIDTH + CW;

  typedef enum logic [1:0] {S_EMPTY, S_LOAD, S_RUN} state_e;

  state_e                  state_q, state_d;
  logic [CW-1:0]           count_q, count_d;
  logic                    ovf_q, ovf_d;
  logic                    load_ready, load_we;
  logic                    req_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   instr_q;
  logic                    fault_q, ivld_q;
  logic [DATA_WIDTH-1:0]   mem [NUM_INSTRUCTIONS];

  assign load_ready = (state_q == S_LOAD) && (count_q < CW'(NUM_INSTRUCTIONS));

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    load_we = 1'b0;
    if (i_Load_Start) begin
      // Start dominates: any word or Done offered in the same cycle is discarded.
      state_d = S_LOAD;
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (state_q == S_LOAD) begin
      if (i_Load_Valid) begin
        if (load_ready) begin
          load_we = 1'b1;
          count_d = count_q + CW'(1);
        end else begin
          ovf_d = 1'b1;
        end
      end
      if (i_Load_Done) state_d = S_RUN;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_EMPTY;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (load_we) mem[count_q[IW-1:0]] <= i_Load_Data;
  end

  // Second fetch stage: range is checked against the full address so that
  // high address bits never alias back into the loaded program.
  logic [ADDR_WIDTH-1:0] idx;
  logic                  fault;
  assign idx   = addr_q >> 2;
  assign fault = (addr_q[1:0] != 2'b00) || (CMPW'(idx) >= CMPW'(count_q));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_q   <= 1'b0;
      addr_q  <= '0;
      instr_q <= '0;
      fault_q <= 1'b0;
      ivld_q  <= 1'b0;
    end else begin
      req_q  <= i_Fetch_Req && (state_q == S_RUN);
      addr_q <= i_Instruction_Address;
      ivld_q <= req_q;
      if (req_q) begin
        instr_q <= fault ? NOP_WORD : mem[idx[IW-1:0]];
        fault_q <= fault;
      end
    end
  end

  assign o_Load_Ready        = load_ready;
  assign o_Load_Overflow     = ovf_q;
  assign o_Loaded_Count      = count_q;
  assign o_Run               = (state_q == S_RUN);
  assign o_Instruction       = instr_q;
  assign o_Instruction_Valid = ivld_q;
  assign o_Fault             = fault_q;

endmodule

// File: tb/tb_instruction_memory_loadable.sv
// Directed bench: main DUT with 64 words, a second 2-word instance for overflow.
module tb_instruction_memory_loadable;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        st, vl, dn, rq;
  logic [31:0] data, addr;

  logic        rdy, ovf, run, iv, flt;
  logic [6:0]  cnt;
  logic [31:0] ins;
  logic        rdy2, ovf2, run2, iv2, flt2;
  logic [1:0]  cnt2;
  logic [31:0] ins2;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  instruction_memory_loadable dut (
    .clk(clk), .reset_n(reset_n),
    .i_Load_Start(st), .i_Load_Valid(vl), .i_Load_Data(data), .i_Load_Done(dn),
    .o_Load_Ready(rdy), .o_Load_Overflow(ovf), .o_Loaded_Count(cnt), .o_Run(run),
    .i_Fetch_Req(rq), .i_Instruction_Address(addr),
    .o_Instruction(ins), .o_Instruction_Valid(iv), .o_Fault(flt)
  );

  instruction_memory_loadable #(.NUM_INSTRUCTIONS(2)) dut2 (
    .clk(clk), .reset_n(reset_n),
    .i_Load_Start(st), .i_Load_Valid(vl), .i_Load_Data(data), .i_Load_Done(dn),
    .o_Load_Ready(rdy2), .o_Load_Overflow(ovf2), .o_Loaded_Count(cnt2), .o_Run(run2),
    .i_Fetch_Req(rq), .i_Instruction_Address(addr),
    .o_Instruction(ins2), .o_Instruction_Valid(iv2), .o_Fault(flt2)
  );

  typedef struct {
    logic        st, vl, dn, rq;
    logic [31:0] data, addr;
    logic        rdy;
    logic [6:0]  cnt;
    logic        run, iv;
    logic [31:0] ins;
    logic        flt, ovf;
  } vec_t;

  localparam logic [31:0] NOP = 32'hE1A00000;
  localparam logic [31:0] W0 = 32'hE3A00001, W1 = 32'hE3A01000,
                          W2 = 32'hE4010000, W3 = 32'hE1A01002;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic s, input logic v, input logic [31:0] d,
                       input logic n, input logic r, input logic [31:0] a);
    st = s; vl = v; data = d; dn = n; rq = r; addr = a;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t tbl [24];

  initial begin
    //         st  vl  dn  rq  data  addr          rdy cnt run iv  ins flt ovf
    tbl[0]  = '{1, 0, 0, 0, 0,  0,            1, 0, 0, 0, 0,   0, 0};
    tbl[1]  = '{0, 1, 0, 0, W0, 0,            1, 1, 0, 0, 0,   0, 0};
    tbl[2]  = '{0, 1, 0, 0, W1, 0,            1, 2, 0, 0, 0,   0, 0};
    tbl[3]  = '{0, 1, 0, 0, W2, 0,            1, 3, 0, 0, 0,   0, 0};
    tbl[4]  = '{0, 0, 1, 0, 0,  0,            0, 3, 1, 0, 0,   0, 0};
    tbl[5]  = '{0, 0, 0, 1, 0,  0,            0, 3, 1, 0, 0,   0, 0};
    tbl[6]  = '{0, 0, 0, 1, 0,  4,            0, 3, 1, 1, W0,  0, 0};
    tbl[7]  = '{0, 0, 0, 1, 0,  8,            0, 3, 1, 1, W1,  0, 0};
    tbl[8]  = '{0, 0, 0, 1, 0,  12,           0, 3, 1, 1, W2,  0, 0};
    tbl[9]  = '{0, 0, 0, 1, 0,  6,            0, 3, 1, 1, NOP, 1, 0};
    tbl[10] = '{0, 0, 0, 1, 0,  32'hFFFFFFFC, 0, 3, 1, 1, NOP, 1, 0};
    tbl[11] = '{0, 0, 0, 1, 0,  0,            0, 3, 1, 1, NOP, 1, 0};
    tbl[12] = '{0, 0, 0, 0, 0,  0,            0, 3, 1, 1, W0,  0, 0};
    tbl[13] = '{0, 0, 0, 0, 0,  0,            0, 3, 1, 0, W0,  0, 0};
    tbl[14] = '{1, 1, 0, 0, W3, 0,            1, 0, 0, 0, W0,  0, 0};
    tbl[15] = '{0, 1, 0, 0, W0, 0,            1, 1, 0, 0, W0,  0, 0};
    tbl[16] = '{0, 1, 0, 0, W1, 0,            1, 2, 0, 0, W0,  0, 0};
    tbl[17] = '{0, 1, 0, 0, W2, 0,            1, 3, 0, 0, W0,  0, 0};
    tbl[18] = '{0, 1, 1, 0, W3, 0,            0, 4, 1, 0, W0,  0, 0};
    tbl[19] = '{0, 0, 0, 1, 0,  12,           0, 4, 1, 0, W0,  0, 0};
    tbl[20] = '{0, 0, 0, 0, 0,  0,            0, 4, 1, 1, W3,  0, 0};
    tbl[21] = '{1, 0, 1, 0, 0,  0,            1, 0, 0, 0, W3,  0, 0};
    tbl[22] = '{0, 0, 0, 1, 0,  0,            1, 0, 0, 0, W3,  0, 0};
    tbl[23] = '{0, 0, 0, 1, 0,  0,            1, 0, 0, 0, W3,  0, 0};

    drive(0, 0, 0, 0, 0, 0);
    reset_n = 1'b0;
    #12;
    chk("reset_count", 32'(cnt), 0);
    chk("reset_instr", ins, 0);
    chk("reset_run",   32'(run), 0);
    reset_n = 1'b1;
    #2;

    // Fetches while EMPTY produce nothing.
    drive(0, 0, 0, 0, 1, 0);
    step(); chk("empty_req_v0", 32'(iv), 0);
    step(); chk("empty_req_v1", 32'(iv), 0);
    chk("empty_req_ins", ins, 0);

    for (int i = 0; i < 24; i++) begin
      drive(tbl[i].st, tbl[i].vl, tbl[i].data, tbl[i].dn, tbl[i].rq, tbl[i].addr);
      step();
      chk($sformatf("v%0d_rdy", i),   32'(rdy),  32'(tbl[i].rdy));
      chk($sformatf("v%0d_cnt", i),   32'(cnt),  32'(tbl[i].cnt));
      chk($sformatf("v%0d_run", i),   32'(run),  32'(tbl[i].run));
      chk($sformatf("v%0d_valid", i), 32'(iv),   32'(tbl[i].iv));
      chk($sformatf("v%0d_instr", i), ins,       tbl[i].ins);
      chk($sformatf("v%0d_fault", i), 32'(flt),  32'(tbl[i].flt));
      chk($sformatf("v%0d_ovf", i),   32'(ovf),  32'(tbl[i].ovf));
    end

    // Asynchronous reset in the middle of a load.
    drive(1, 0, 0, 0, 0, 0); step();
    drive(0, 1, W0, 0, 0, 0); step();
    drive(0, 1, W1, 0, 0, 0); step();
    drive(0, 1, W2, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0);
    chk("midload_cnt", 32'(cnt), 3);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_cnt",   32'(cnt), 0);
    chk("arst_rdy",   32'(rdy), 0);
    chk("arst_valid", 32'(iv),  0);
    chk("arst_instr", ins,      0);
    chk("arst_run",   32'(run), 0);
    #3;
    reset_n = 1'b1;
    #2;

    // Overflow on the 2-word instance.
    drive(1, 0, 0, 0, 0, 0); step();
    chk("ovf_start_rdy", 32'(rdy2), 1);
    drive(0, 1, W0, 0, 0, 0); step();
    chk("ovf_w1_cnt", 32'(cnt2), 1);
    chk("ovf_w1_rdy", 32'(rdy2), 1);
    drive(0, 1, W1, 0, 0, 0); step();
    chk("ovf_w2_cnt", 32'(cnt2), 2);
    chk("ovf_w2_rdy", 32'(rdy2), 0);
    chk("ovf_w2_flag", 32'(ovf2), 0);
    drive(0, 1, W2, 0, 0, 0); step();
    chk("ovf_w3_cnt", 32'(cnt2), 2);
    chk("ovf_w3_flag", 32'(ovf2), 1);
    drive(0, 0, 0, 0, 0, 0); step();
    chk("ovf_sticky", 32'(ovf2), 1);
    drive(1, 0, 0, 0, 0, 0); step();
    chk("ovf_clr_flag", 32'(ovf2), 0);
    chk("ovf_clr_cnt",  32'(cnt2), 0);
    drive(0, 0, 0, 0, 0, 0); step();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
